// File: rtl/alu_sort_sequencer.sv
// Sequencer for the SORT extension: bubble-sorts an N-entry buffer of 32-bit words
// in ascending unsigned order by driving the EX-stage ALU's min/max operations.
module alu_sort_sequencer #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             load_en,
  input  logic [IDX_W-1:0] load_idx,
  input  logic [31:0]      load_data,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [31:0]      rd_data,
  output logic [3:0]       alu_cmd,
  output logic [31:0]      alu_val1,
  output logic [31:0]      alu_val2,
  input  logic [31:0]      alu_result,
  output logic             busy,
  output logic             done
);

  localparam logic [3:0] CMD_NOP = 4'b0000;
  localparam logic [3:0] CMD_MIN = 4'b1110;
  localparam logic [3:0] CMD_MAX = 4'b1111;

  // Last pass index; one extra bit keeps the N-2-p subtraction from wrapping.
  localparam logic [IDX_W:0] LAST_P = (IDX_W + 1)'(N - 2);

  typedef enum logic [1:0] {
    IDLE,
    MIN,
    MAX,
    DONE
  } state_t;

  state_t             state_reg, state_next;
  logic [IDX_W-1:0]   p_reg, p_next;
  logic [IDX_W-1:0]   i_reg, i_next;
  logic [31:0]        min_r_reg, min_r_next;
  logic [31:0]        mem_reg  [N];
  logic [31:0]        mem_next [N];

  logic [IDX_W-1:0]   i_plus1;
  logic [IDX_W:0]     i_limit;

  assign i_plus1 = i_reg + 1'b1;
  assign i_limit = LAST_P - {1'b0, p_reg};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      p_reg     <= '0;
      i_reg     <= '0;
      min_r_reg <= '0;
      for (int k = 0; k < N; k++) begin
        mem_reg[k] <= '0;
      end
    end else begin
      state_reg <= state_next;
      p_reg     <= p_next;
      i_reg     <= i_next;
      min_r_reg <= min_r_next;
      for (int k = 0; k < N; k++) begin
        mem_reg[k] <= mem_next[k];
      end
    end
  end

  // Next-state and pass/index sequencing.
  always_comb begin
    state_next = state_reg;
    p_next     = p_reg;
    i_next     = i_reg;
    min_r_next = min_r_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = MIN;
          p_next     = '0;
          i_next     = '0;
        end
      end
      MIN: begin
        min_r_next = alu_result;
        state_next = MAX;
      end
      MAX: begin
        if ({1'b0, i_reg} < i_limit) begin
          i_next     = i_plus1;
          state_next = MIN;
        end else if ({1'b0, p_reg} < LAST_P) begin
          p_next     = p_reg + 1'b1;
          i_next     = '0;
          state_next = MIN;
        end else begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Buffer writes: software loads only in IDLE; the exchange lands in MAX.
  always_comb begin
    for (int k = 0; k < N; k++) begin
      mem_next[k] = mem_reg[k];
      if (state_reg == IDLE && load_en && load_idx == IDX_W'(k)) begin
        mem_next[k] = load_data;
      end
      if (state_reg == MAX && i_reg == IDX_W'(k)) begin
        mem_next[k] = min_r_reg;
      end
      if (state_reg == MAX && i_plus1 == IDX_W'(k)) begin
        mem_next[k] = alu_result;
      end
    end
  end

  // Outputs decode from registered state only; alu_result never reaches a port.
  always_comb begin
    alu_cmd  = CMD_NOP;
    alu_val1 = '0;
    alu_val2 = '0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state_reg)
      MIN: begin
        alu_cmd  = CMD_MIN;
        alu_val1 = mem_reg[i_reg];
        alu_val2 = mem_reg[i_plus1];
        busy     = 1'b1;
      end
      MAX: begin
        alu_cmd  = CMD_MAX;
        alu_val1 = mem_reg[i_reg];
        alu_val2 = mem_reg[i_plus1];
        busy     = 1'b1;
      end
      DONE: begin
        done = 1'b1;
      end
      default: begin
        alu_cmd = CMD_NOP;
      end
    endcase
  end

  assign rd_data = mem_reg[rd_idx];

endmodule

// File: tb/tb_alu_sort_sequencer.sv
// Randomised self-checking bench for alu_sort_sequencer with a behavioural ALU and
// a queue-sort reference for final buffer contents.
module tb_alu_sort_sequencer;

  logic        clk;
  logic        rst;
  logic        start;
  logic        load_en;
  logic [1:0]  load_idx;
  logic [31:0] load_data;
  logic [1:0]  rd_idx;
  logic [31:0] rd_data;
  logic [3:0]  alu_cmd;
  logic [31:0] alu_val1;
  logic [31:0] alu_val2;
  logic [31:0] alu_result;
  logic        busy;
  logic        done;

  int checks;
  int failures;

  alu_sort_sequencer #(.N(4), .IDX_W(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .load_en    (load_en),
    .load_idx   (load_idx),
    .load_data  (load_data),
    .rd_idx     (rd_idx),
    .rd_data    (rd_data),
    .alu_cmd    (alu_cmd),
    .alu_val1   (alu_val1),
    .alu_val2   (alu_val2),
    .alu_result (alu_result),
    .busy       (busy),
    .done       (done)
  );

  // Behavioural ALU: unsigned min/max.
  always_comb begin
    case (alu_cmd)
      4'b1110: alu_result = (alu_val1 > alu_val2) ? alu_val2 : alu_val1;
      4'b1111: alu_result = (alu_val1 > alu_val2) ? alu_val1 : alu_val2;
      default: alu_result = 32'h0;
    endcase
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [1:0] idx, input logic [31:0] data);
    load_en   = 1'b1;
    load_idx  = idx;
    load_data = data;
    step();
    load_en   = 1'b0;
  endtask

  // mode 0: plain sort; 1: start+load injected in cycle 5; 2: reset in cycle 6;
  // 3: same-cycle load of idx 0 = 0 together with start.
  task automatic run_sort(input string name, input logic [31:0] vals [4], input int mode);
    logic [31:0] m [4];
    logic [31:0] ev1 [6];
    logic [31:0] ev2 [6];
    logic [31:0] q [$];
    logic [31:0] tmp;
    logic [3:0]  exp_cmd;
    logic        exp_busy;
    logic        exp_done;
    logic [31:0] exp_v1;
    logic [31:0] exp_v2;
    int          t;

    for (int k = 0; k < 4; k++) begin
      load_word(2'(k), vals[k]);
      m[k] = vals[k];
    end
    if (mode == 3) m[0] = 32'h0;

    // Expected operand pairs for each compare-exchange of an ascending bubble sort.
    t = 0;
    for (int p = 0; p <= 2; p++) begin
      for (int i = 0; i <= 2 - p; i++) begin
        ev1[t] = m[i];
        ev2[t] = m[i+1];
        if (m[i] > m[i+1]) begin
          tmp = m[i]; m[i] = m[i+1]; m[i+1] = tmp;
        end
        t++;
      end
    end
    q = {};
    for (int k = 0; k < 4; k++) q.push_back(vals[k]);
    if (mode == 3) q[0] = 32'h0;
    q.sort();

    start = 1'b1;
    if (mode == 3) begin
      load_en   = 1'b1;
      load_idx  = 2'd0;
      load_data = 32'h0;
    end
    step();
    start   = 1'b0;
    load_en = 1'b0;

    for (int c = 1; c <= 13; c++) begin
      if (c <= 12) begin
        exp_cmd  = (c % 2 == 1) ? 4'b1110 : 4'b1111;
        exp_busy = 1'b1;
        exp_done = 1'b0;
        exp_v1   = ev1[(c-1)/2];
        exp_v2   = ev2[(c-1)/2];
      end else begin
        exp_cmd  = 4'b0000;
        exp_busy = 1'b0;
        exp_done = 1'b1;
        exp_v1   = 32'h0;
        exp_v2   = 32'h0;
      end
      checks++;
      if ({busy, done, alu_cmd, alu_val1, alu_val2} !== {exp_busy, exp_done, exp_cmd, exp_v1, exp_v2}) begin
        failures++;
        $display("FAIL %s cycle%0d: got busy=%b done=%b cmd=%b v1=%h v2=%h, want busy=%b done=%b cmd=%b v1=%h v2=%h",
                 name, c, busy, done, alu_cmd, alu_val1, alu_val2, exp_busy, exp_done, exp_cmd, exp_v1, exp_v2);
      end
      if (mode == 1 && c == 5) begin
        start     = 1'b1;
        load_en   = 1'b1;
        load_idx  = 2'd2;
        load_data = 32'd9;
      end
      if (mode == 2 && c == 6) rst = 1'b1;
      step();
      start   = 1'b0;
      load_en = 1'b0;
      if (mode == 2 && c == 6) begin
        rst = 1'b0;
        checks++;
        if ({busy, done, alu_cmd, alu_val1, alu_val2} !== {1'b0, 1'b0, 4'b0000, 32'h0, 32'h0}) begin
          failures++;
          $display("FAIL %s after_rst: got busy=%b done=%b cmd=%b v1=%h v2=%h, want all zero",
                   name, busy, done, alu_cmd, alu_val1, alu_val2);
        end
        for (int k = 0; k < 4; k++) begin
          rd_idx = 2'(k);
          #1;
          checks++;
          if (rd_data !== 32'h0) begin
            failures++;
            $display("FAIL %s rst_mem[%0d]: got %h want 00000000", name, k, rd_data);
          end
        end
        return;
      end
    end

    // One cycle after done: back in IDLE.
    checks++;
    if ({busy, done, alu_cmd} !== {1'b0, 1'b0, 4'b0000}) begin
      failures++;
      $display("FAIL %s post_done: got busy=%b done=%b cmd=%b want 0 0 0000", name, busy, done, alu_cmd);
    end
    for (int k = 0; k < 4; k++) begin
      rd_idx = 2'(k);
      #1;
      checks++;
      if (rd_data !== q[k]) begin
        failures++;
        $display("FAIL %s mem[%0d]: got %h want %h", name, k, rd_data, q[k]);
      end
    end
    $display("sort %s: in=%h %h %h %h out=%h %h %h %h", name,
             vals[0], vals[1], vals[2], vals[3], q[0], q[1], q[2], q[3]);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    checks++;
    if ({busy, done, alu_cmd, alu_val1, alu_val2} !== {1'b0, 1'b0, 4'b0000, 32'h0, 32'h0}) begin
      failures++;
      $display("FAIL reset_outputs: got busy=%b done=%b cmd=%b v1=%h v2=%h want all zero",
               busy, done, alu_cmd, alu_val1, alu_val2);
    end
    for (int k = 0; k < 4; k++) begin
      rd_idx = 2'(k);
      #1;
      checks++;
      if (rd_data !== 32'h0) begin
        failures++;
        $display("FAIL reset_mem[%0d]: got %h want 00000000", k, rd_data);
      end
    end
    $display("reset: checked outputs and buffer");
  endtask

  task automatic test_basic();
    run_sort("basic", '{32'd5, 32'd1, 32'd4, 32'd2}, 0);
  endtask

  task automatic test_unsigned();
    run_sort("unsigned", '{32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 32'd7}, 0);
  endtask

  task automatic test_sorted_and_dups();
    run_sort("presorted", '{32'd1, 32'd2, 32'd3, 32'd4}, 0);
    run_sort("duplicates", '{32'd3, 32'd3, 32'd1, 32'd1}, 0);
  endtask

  task automatic test_ignore_while_busy();
    run_sort("ignore_busy", '{32'd20, 32'd3, 32'd11, 32'd6}, 1);
  endtask

  task automatic test_reset_mid_sort();
    run_sort("rst_mid", '{32'd40, 32'd30, 32'd20, 32'd10}, 2);
    run_sort("after_rst", '{32'd7, 32'd100, 32'd2, 32'd50}, 0);
  endtask

  task automatic test_same_cycle_load();
    run_sort("load_with_start", '{32'd8, 32'd6, 32'd7, 32'd5}, 3);
  endtask

  task automatic test_random();
    logic [31:0] v [4];
    for (int n = 0; n < 8; n++) begin
      for (int k = 0; k < 4; k++) begin
        v[k] = (n % 2 == 0) ? $urandom() : 32'($urandom_range(0, 3));
      end
      run_sort($sformatf("random%0d", n), v, 0);
    end
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst       = 1'b0;
    start     = 1'b0;
    load_en   = 1'b0;
    load_idx  = 2'd0;
    load_data = 32'h0;
    rd_idx    = 2'd0;
    test_reset();
    test_basic();
    test_unsigned();
    test_sorted_and_dups();
    test_ignore_while_busy();
    test_reset_mid_sort();
    test_same_cycle_load();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
